// File: rtl/rfifo_fwft.sv
// First-word-fall-through read adapter: pulls words out of the FIFO memory as soon as
// they are available and local space is reserved, and presents them as a valid/ready stream.
module rfifo_fwft #(
  parameter int DSIZE = 8,
  parameter int RDLAT = 0
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic [1:0]       occ
);

  localparam int         BDEPTH = RDLAT + 2;
  localparam logic [1:0] LAST   = 2'(BDEPTH - 1);

  logic [DSIZE-1:0] r_buf [4];
  logic [1:0]       r_head;
  logic [1:0]       r_tail;
  logic [1:0]       r_occ;
  logic             r_inflight;

  logic             w_rinc;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_reserved;

  function automatic logic [1:0] nxt_idx(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // A request is only issued if a slot is already reserved for it, counting the
  // word still travelling through the memory read pipeline.
  assign w_reserved = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_rinc     = !rrst && !rempty && (w_reserved < 3'(BDEPTH));
  assign w_push     = (RDLAT == 0) ? w_rinc : r_inflight;
  assign w_pop      = (r_occ != 2'd0) && dready;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_tail] <= rdata;
        r_tail        <= nxt_idx(r_tail);
      end
      if (w_pop) r_head <= nxt_idx(r_head);
      if (w_push && !w_pop)      r_occ <= r_occ + 2'd1;
      else if (!w_push && w_pop) r_occ <= r_occ - 2'd1;
      r_inflight <= (RDLAT == 1) && w_rinc;
    end
  end

  a_credit: assert property (@(posedge rclk) disable iff (rrst)
    !(w_push && (r_occ == 2'(BDEPTH))));

  assign rinc   = w_rinc;
  assign dout   = r_buf[r_head];
  assign dvalid = (r_occ != 2'd0);
  assign occ    = r_occ;

endmodule

// File: tb/tb_rfifo_fwft.sv
// Directed bench for rfifo_fwft: one instance per read latency, each fed by a
// memory model that returns 0x10, 0x11, ... per rinc and restarts on reset.
module tb_rfifo_fwft;
  logic       clk;
  logic       rrst0, rempty0, dready0, rinc0, dvalid0;
  logic [7:0] rdata0, dout0, cnt0;
  logic [1:0] occ0;
  logic       rrst1, rempty1, dready1, rinc1, dvalid1;
  logic [7:0] rdata1, dout1, cnt1;
  logic [1:0] occ1;
  int checks = 0;
  int errors = 0;

  rfifo_fwft #(.DSIZE(8), .RDLAT(0)) u_dut0 (
    .rclk(clk), .rrst(rrst0), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0),
    .dout(dout0), .dvalid(dvalid0), .dready(dready0), .occ(occ0));

  rfifo_fwft #(.DSIZE(8), .RDLAT(1)) u_dut1 (
    .rclk(clk), .rrst(rrst1), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
    .dout(dout1), .dvalid(dvalid1), .dready(dready1), .occ(occ1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency memory: data for the current rinc is already on rdata0.
  assign rdata0 = 8'h10 + cnt0;
  always @(posedge clk) begin
    if (rrst0) cnt0 <= 8'd0;
    else if (rinc0) cnt0 <= cnt0 + 8'd1;
  end

  // One-cycle memory: data for rinc at cycle t is on rdata1 during t+1.
  always @(posedge clk) begin
    if (rrst1) cnt1 <= 8'd0;
    else if (rinc1) begin
      rdata1 <= 8'h10 + cnt1;
      cnt1   <= cnt1 + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rrst0 = 1'b1;
    tick();
    tick();
    rrst0 = 1'b0;
    #1;
  endtask

  task automatic reset1();
    rrst1 = 1'b1;
    tick();
    tick();
    rrst1 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rrst0 = 1'b1; rempty0 = 1'b0; dready0 = 1'b1;
    rrst1 = 1'b1; rempty1 = 1'b0; dready1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (rinc0 !== 1'b0 || dvalid0 !== 1'b0 || occ0 !== 2'd0) begin
        errors++;
        $display("FAIL reset0 c=%0d rinc=%b dvalid=%b occ=%0d required 0 0 0", c, rinc0, dvalid0, occ0);
      end
      checks++;
      if (rinc1 !== 1'b0 || dvalid1 !== 1'b0 || occ1 !== 2'd0) begin
        errors++;
        $display("FAIL reset1 c=%0d rinc=%b dvalid=%b occ=%0d required 0 0 0", c, rinc1, dvalid1, occ1);
      end
    end
    rrst0 = 1'b0;
    #1;
    checks++;
    if (rinc0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release rinc=%b required 1", rinc0);
    end
  endtask

  task automatic test_stream0();
    dready0 = 1'b1; rempty0 = 1'b0;
    reset0();
    checks++;
    if (rinc0 !== 1'b1 || dvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL stream0_first rinc=%b dvalid=%b required 1 0", rinc0, dvalid0);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (dvalid0 !== 1'b1 || dout0 !== 8'(32'h10 + k) || occ0 !== 2'd1) begin
        errors++;
        $display("FAIL stream0 k=%0d dvalid=%b dout=%h occ=%0d required 1 %h 1",
                 k, dvalid0, dout0, occ0, 8'(32'h10 + k));
      end
    end
  endtask

  task automatic test_backpressure0();
    int n;
    dready0 = 1'b0; rempty0 = 1'b0;
    reset0();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (rinc0 === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 2 || occ0 !== 2'd2 || dout0 !== 8'h10 || rinc0 !== 1'b0) begin
      errors++;
      $display("FAIL bp0_hold pulses=%0d occ=%0d dout=%h rinc=%b required 2 2 10 0", n, occ0, dout0, rinc0);
    end
    dready0 = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dvalid0 !== 1'b1 || dout0 !== 8'(32'h10 + k)) begin
        errors++;
        $display("FAIL bp0_drain k=%0d dvalid=%b dout=%h required 1 %h", k, dvalid0, dout0, 8'(32'h10 + k));
      end
      if (k == 1) begin
        checks++;
        if (rinc0 !== 1'b1) begin
          errors++;
          $display("FAIL bp0_resume rinc=%b required 1", rinc0);
        end
      end
      tick();
    end
  endtask

  task automatic test_empty0();
    dready0 = 1'b1; rempty0 = 1'b0;
    reset0();
    tick();
    checks++;
    if (dout0 !== 8'h10 || dvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL empty0_w0 dout=%h dvalid=%b required 10 1", dout0, dvalid0);
    end
    tick();
    checks++;
    if (dout0 !== 8'h11 || dvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL empty0_w1 dout=%h dvalid=%b required 11 1", dout0, dvalid0);
    end
    tick();
    rempty0 = 1'b1;
    #1;
    checks++;
    if (rinc0 !== 1'b0 || dout0 !== 8'h12 || dvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL empty0_w2 rinc=%b dout=%h dvalid=%b required 0 12 1", rinc0, dout0, dvalid0);
    end
    tick();
    checks++;
    if (dvalid0 !== 1'b0 || occ0 !== 2'd0) begin
      errors++;
      $display("FAIL empty0_drained dvalid=%b occ=%0d required 0 0", dvalid0, occ0);
    end
    tick();
    tick();
    rempty0 = 1'b0;
    #1;
    checks++;
    if (rinc0 !== 1'b1) begin
      errors++;
      $display("FAIL empty0_restart rinc=%b required 1", rinc0);
    end
    tick();
    checks++;
    if (dout0 !== 8'h13 || dvalid0 !== 1'b1) begin
      errors++;
      $display("FAIL empty0_resume dout=%h dvalid=%b required 13 1", dout0, dvalid0);
    end
  endtask

  task automatic test_stream1();
    dready1 = 1'b1; rempty1 = 1'b0;
    reset1();
    checks++;
    if (rinc1 !== 1'b1 || dvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL stream1_first rinc=%b dvalid=%b required 1 0", rinc1, dvalid1);
    end
    tick();
    checks++;
    if (dvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL stream1_latency dvalid=%b required 0", dvalid1);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (dvalid1 !== 1'b1 || dout1 !== 8'(32'h10 + k)) begin
        errors++;
        $display("FAIL stream1 k=%0d dvalid=%b dout=%h required 1 %h", k, dvalid1, dout1, 8'(32'h10 + k));
      end
    end
  endtask

  task automatic test_backpressure1();
    int n;
    dready1 = 1'b0; rempty1 = 1'b0;
    reset1();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (rinc1 === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 3 || occ1 !== 2'd3 || dout1 !== 8'h10) begin
      errors++;
      $display("FAIL bp1_hold pulses=%0d occ=%0d dout=%h required 3 3 10", n, occ1, dout1);
    end
    dready1 = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dvalid1 !== 1'b1 || dout1 !== 8'(32'h10 + k)) begin
        errors++;
        $display("FAIL bp1_drain k=%0d dvalid=%b dout=%h required 1 %h", k, dvalid1, dout1, 8'(32'h10 + k));
      end
      tick();
    end
  endtask

  task automatic test_midreset1();
    dready1 = 1'b0; rempty1 = 1'b0;
    reset1();
    tick();
    tick();
    tick();
    checks++;
    if (occ1 !== 2'd2 || rinc1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst1_pre occ=%0d rinc=%b required 2 0", occ1, rinc1);
    end
    rrst1 = 1'b1;
    tick();
    checks++;
    if (dvalid1 !== 1'b0 || occ1 !== 2'd0 || rinc1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst1_clear dvalid=%b occ=%0d rinc=%b required 0 0 0", dvalid1, occ1, rinc1);
    end
    rrst1 = 1'b0; dready1 = 1'b1;
    #1;
    checks++;
    if (rinc1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst1_release rinc=%b required 1", rinc1);
    end
    tick();
    checks++;
    if (occ1 !== 2'd0 || dvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst1_late occ=%0d dvalid=%b required 0 0", occ1, dvalid1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dvalid1 !== 1'b1 || dout1 !== 8'(32'h10 + k)) begin
        errors++;
        $display("FAIL midrst1_restart k=%0d dvalid=%b dout=%h required 1 %h", k, dvalid1, dout1, 8'(32'h10 + k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream0();
    test_backpressure0();
    test_empty0();
    test_stream1();
    test_backpressure1();
    test_midreset1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
